// File: rtl/smem_hsi_pkg.sv
// Shared definitions for the SMEM HSI link: FSM states, word width and the
// word-index -> (segment, lane) mapping used by both the row writer and receiver.
package smem_hsi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } hsi_state_e;

    localparam int HSI_WORD_W = 32;
    localparam int ROW_BITS   = 2048;
    localparam int ROW_WORDS  = ROW_BITS / HSI_WORD_W;
    localparam int WC_W       = $clog2(ROW_WORDS);

    typedef struct packed {
        logic [1:0]      seg;
        logic [WC_W-1:0] lane;
    } word_pos_t;

    // Word wc of a row lives in segment wc/eps at 32-bit lane wc%eps.
    function automatic word_pos_t word_pos(input logic [WC_W-1:0] wc, input int eps);
        word_pos_t p;
        p.seg  = 2'(int'(wc) / eps);
        p.lane = WC_W'(int'(wc) % eps);
        return p;
    endfunction

endpackage

// File: rtl/smem_hsi_receiver.sv
// Reassembles HSI command+data beats into complete SMEM rows, enforcing the
// inter-row idle gap and reporting stray, abort and gap protocol errors.
module smem_hsi_receiver
    import smem_hsi_pkg::*;
#(
    parameter int DW      = 512,
    parameter int MIN_GAP = 7
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [31:0]     hsi_tdata,
    input  logic            hsi_tuser,
    input  logic            hsi_tvalid,
    output logic [31:0]     row_index,
    output logic [DW-1:0]   row_data0,
    output logic [DW-1:0]   row_data1,
    output logic [DW-1:0]   row_data2,
    output logic [DW-1:0]   row_data3,
    output logic            row_valid,
    output logic            busy,
    output logic            err_abort,
    output logic            err_stray,
    output logic            err_gap,
    output logic [31:0]     row_count,
    output logic [15:0]     err_count
);

    localparam int EPS   = DW / HSI_WORD_W;
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(ROW_WORDS - 1);

    hsi_state_e          state_r, state_s;
    logic [WC_W-1:0]     wc_r, wc_s;
    logic [31:0]         pend_r, pend_s;
    logic [GAP_W-1:0]    gap_r, gap_s;
    logic [4*DW-1:0]     asm_r, asm_s;
    logic                beat_we_s;
    logic                done_s, abort_s, stray_s, gaperr_s;
    word_pos_t           pos_s;

    logic [31:0]         row_index_r;
    logic [4*DW-1:0]     row_data_r;
    logic                row_valid_r, busy_r;
    logic                err_abort_r, err_stray_r, err_gap_r;
    logic [31:0]         row_count_r;
    logic [15:0]         err_count_r;

    // Next-state, word counter, gap counter and error decode.
    always_comb begin
        state_s   = state_r;
        wc_s      = wc_r;
        pend_s    = pend_r;
        gap_s     = gap_r;
        beat_we_s = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        stray_s   = 1'b0;
        gaperr_s  = 1'b0;
        pos_s     = word_pos(wc_r, EPS);
        if (!hsi_tvalid) begin
            if (gap_r < GAP_MAX) begin
                gap_s = gap_r + GAP_W'(1);
            end else begin
                gap_s = gap_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hsi_tuser) begin
                        pend_s   = hsi_tdata;
                        wc_s     = '0;
                        state_s  = ST_DATA;
                        gaperr_s = (gap_r < GAP_MAX);
                    end else begin
                        stray_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (hsi_tuser) begin
                        abort_s = 1'b1;
                        pend_s  = hsi_tdata;
                        wc_s    = '0;
                    end else begin
                        beat_we_s = 1'b1;
                        if (wc_r == WC_LAST) begin
                            done_s  = 1'b1;
                            wc_s    = '0;
                            gap_s   = '0;
                            state_s = ST_IDLE;
                        end else begin
                            wc_s = wc_r + WC_W'(1);
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    wc_s    = '0;
                end
            endcase
        end
    end

    // Per-lane write enables into the flat assembly buffer.
    always_comb begin
        asm_s = asm_r;
        for (int i = 0; i < ROW_WORDS; i++) begin
            if (beat_we_s && ((int'(pos_s.seg) * EPS + int'(pos_s.lane)) == i)) begin
                asm_s[i*HSI_WORD_W +: HSI_WORD_W] = hsi_tdata;
            end else begin
                asm_s[i*HSI_WORD_W +: HSI_WORD_W] = asm_r[i*HSI_WORD_W +: HSI_WORD_W];
            end
        end
    end

    // State, buffer, registered outputs and counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            wc_r        <= '0;
            pend_r      <= 32'd0;
            gap_r       <= GAP_MAX;
            asm_r       <= '0;
            row_index_r <= 32'd0;
            row_data_r  <= '0;
            row_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_abort_r <= 1'b0;
            err_stray_r <= 1'b0;
            err_gap_r   <= 1'b0;
            row_count_r <= 32'd0;
            err_count_r <= 16'd0;
        end else begin
            state_r     <= state_s;
            wc_r        <= wc_s;
            pend_r      <= pend_s;
            gap_r       <= gap_s;
            asm_r       <= asm_s;
            row_valid_r <= done_s;
            busy_r      <= (state_s == ST_DATA);
            err_abort_r <= abort_s;
            err_stray_r <= stray_s;
            err_gap_r   <= gaperr_s;
            if (done_s) begin
                row_index_r <= pend_r;
                row_data_r  <= asm_s;
                row_count_r <= row_count_r + 32'd1;
            end else begin
                row_index_r <= row_index_r;
                row_data_r  <= row_data_r;
                row_count_r <= row_count_r;
            end
            // Only one error source can fire per beat, so a single increment suffices.
            if ((abort_s || stray_s || gaperr_s) && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign row_index = row_index_r;
    assign row_data0 = row_data_r[0*DW +: DW];
    assign row_data1 = row_data_r[1*DW +: DW];
    assign row_data2 = row_data_r[2*DW +: DW];
    assign row_data3 = row_data_r[3*DW +: DW];
    assign row_valid = row_valid_r;
    assign busy      = busy_r;
    assign err_abort = err_abort_r;
    assign err_stray = err_stray_r;
    assign err_gap   = err_gap_r;
    assign row_count = row_count_r;
    assign err_count = err_count_r;

endmodule

// File: doc/smem_hsi_receiver.md
# smem_hsi_receiver

Receives the HSI bus produced by the SMEM row writer and reassembles each transfer into a full SMEM row: one command beat (TUSER=1) carrying the row index, then ROW_WORDS 32-bit data beats (TUSER=0). Used as the sensor-side SMEM model in benches and as a loopback checker on hardware. Also enforces the inter-row idle gap and flags protocol violations. Single clock domain: it runs on the HSI clock, connected as `clk`.

## Interface
- DW, 512: segment width in bits; must be a multiple of 32, and 4·DW must equal 2048.
- MIN_GAP, 7: minimum count of tvalid-low cycles required between the last data beat of a row and the next command beat.
- ROW_WORDS: derived localparam, equal to 4·DW/32 (64 at the default).
- EPS: derived localparam, equal to DW/32 (words per segment).

Ports:
- clk  in  1  HSI clock.
- resetn  in  1  Reset. Synchronous, active-low; clock clk.
- hsi_tdata  in  32  HSI data.
- hsi_tuser  in  1  1 marks a command beat (row index); 0 marks a data beat.
- hsi_tvalid  in  1  Beat valid. There is no backpressure; every valid beat is consumed.
- row_index  out  32  Row index of the most recently completed row.
- row_data0..row_data3  out  DW each  Completed row data, segment 0 through segment 3.
- row_valid  out  1  One-cycle pulse when row_index/row_data* update.
- busy  out  1  High while a row is being collected.
- err_abort  out  1  One-cycle pulse: command beat arrived mid-row.
- err_stray  out  1  One-cycle pulse: data beat arrived with no row open.
- err_gap  out  1  One-cycle pulse: command beat arrived before MIN_GAP idle cycles elapsed.
- row_count  out  32  Count of completed rows; wraps.
- err_count  out  16  Count of all error pulses; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: no row open.
  - DATA: row open, collecting data beats.
- IDLE, command beat (tvalid=1, tuser=1):
  - Latch tdata into the pending index.
  - Set word counter wc=0.
  - Go to DATA.
- IDLE, data beat (tvalid=1, tuser=0):
  - Discard the beat.
  - Pulse err_stray.
- DATA, data beat:
  - Write word wc into the assembly buffer at segment wc/EPS, bits (wc%EPS)·32 +: 32.
  - If wc==ROW_WORDS−1:
    - Copy the pending index and assembly buffer to row_index and row_data*.
    - Pulse row_valid.
    - Increment row_count.
    - Go to IDLE.
  - Otherwise wc++.
- DATA, command beat:
  - Drop the partial row; no output update.
  - Pulse err_abort.
  - Latch the new index, set wc=0, stay in DATA (the new row is accepted).
- DATA, tvalid=0: hold state. Pauses of any length are legal; there is no timeout.
- Gap counter:
  - Cleared to 0 on the cycle the last data beat of a row is accepted.
  - Increments on each tvalid-low cycle, saturating at MIN_GAP.
  - Reset value is MIN_GAP, so the first command after reset is legal.
- Gap check on a command beat in IDLE:
  - If the gap counter is below MIN_GAP, pulse err_gap.
  - The row is still accepted.
- err_count adds 1 for each cycle in which any error pulse is high. Only one error can fire per beat.
- busy = (state==DATA).

## Timing
- All outputs are registered.
- Row completion: row_valid, row_index, row_data* and row_count update on the clock edge that samples the final data beat, so they are visible the cycle after that beat is presented.
- row_data*/row_index hold their value until the next completed row.
- Error pulses appear the cycle after the offending beat and last exactly one cycle.
- Full throughput: a row occupies ROW_WORDS+1 consecutive beats.
- Reset values:
  - State IDLE, wc=0.
  - row_index, row_data*, row_valid, busy, all err_* and both counters: 0.
  - Gap counter: MIN_GAP.
- Reset asserted mid-row: partial row discarded; no row_valid.
- Command beat in the same cycle the gap counter reaches MIN_GAP: the comparison uses the pre-increment value.

## Structure
- Package smem_hsi_pkg holds:
  - The state enum.
  - HSI_WORD_W=32.
  - ROW_WORDS.
  - A function mapping word index to (segment, lane).
- The SMEM writer uses the same package, so both ends share a single definition of word order.
- No sub-module. The assembly buffer is a flat 4·DW register with per-lane write enables decoded from wc.

## Test plan
- Single row, defaults: command 0x0000_0005, then words 0x1000+k for k=0..63 back-to-back.
  - row_valid pulses once, row_index=5.
  - row_data0[31:0]=0x1000; row_data3[511:480]=0x103F.
  - row_count=1, no errors.
- Same row with tvalid low 3 cycles after every 8th word: identical outputs; row_valid is delayed by the pause cycles.
- Command 0x7, 20 data words, command 0x8, then 64 words:
  - err_abort pulses once.
  - Only row 0x8 is reported; err_count=1.
- Two rows separated by 4 idle cycles: err_gap pulses on the second command, both rows complete, err_count=1. With 7 idle cycles, no error.
- Data beat with no open row:
  - err_stray pulses, the beat is discarded, state stays IDLE.
  - 0xFFFF+2 such beats leave err_count=0xFFFF.
- resetn low for 1 cycle at word 30, then a full row 0x9: only row 0x9 is reported; row_count=1.
